fwd_hazard_ctrl: RTL and testbench

- Control-side producer of the 3-bit select codes consumed by the execute-stage 4-way operand muxes (codes 000/001/010/other map to inputs d0/d1/d2/d3).
- Keeps a shadow pipeline of destination-register info for the E, M and W stages and matches it against E-stage source registers to pick forwarding paths.
- Also generates the load-use stall and the branch flush controls for the 5-stage core.

---
 rtl/fwd_hazard_ctrl_if.sv | 31 +++
 rtl/fwd_hazard_ctrl.sv | 98 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode/execute control bundle between the core datapath and the forwarding/hazard unit.
// master = datapath side, slave = the hazard controller.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned RA_W  = 4,
    parameter int unsigned CNT_W = 16
);
    logic              valid_d;
    logic [RA_W-1:0]   ra1_d;
    logic [RA_W-1:0]   ra2_d;
    logic [RA_W-1:0]   wa_d;
    logic              regwrite_d;
    logic              memtoreg_d;
    logic              branch_taken_e;
    logic [2:0]        fwd_a_e;
    logic [2:0]        fwd_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output valid_d, ra1_d, ra2_d, wa_d, regwrite_d, memtoreg_d, branch_taken_e,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
    );

    modport slave (
        input  valid_d, ra1_d, ra2_d, wa_d, regwrite_d, memtoreg_d, branch_taken_e,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and branch flush control for a 5-stage core.
// Tracks destination info for E/M/W in a shadow pipeline and matches it against E sources.
module fwd_hazard_ctrl #(
    parameter int unsigned RA_W   = 4,
    parameter int unsigned PC_REG = 15,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    fwd_hazard_ctrl_if.slave  bus
);
    localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

    logic            e_valid, e_rw, e_mr;
    logic [RA_W-1:0] e_ra1, e_ra2, e_wa;
    logic            m_valid, m_rw;
    logic [RA_W-1:0] m_wa;
    logic            w_valid, w_rw;
    logic [RA_W-1:0] w_wa;
    logic [CNT_W-1:0] cnt;

    logic            m_wr, w_wr;
    logic            ldr_hz;
    logic            stall, flush_e;
    logic [2:0]      fwd_a, fwd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid <= 1'b0;
            m_valid <= 1'b0;
            w_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            e_valid <= bus.valid_d & ~flush_e;
            m_valid <= e_valid;
            w_valid <= m_valid;
            if (stall && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Payload fields are only meaningful under their valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        e_ra1 <= bus.ra1_d;
        e_ra2 <= bus.ra2_d;
        e_wa  <= bus.wa_d;
        e_rw  <= bus.regwrite_d;
        e_mr  <= bus.memtoreg_d;
        m_wa  <= e_wa;
        m_rw  <= e_rw;
        w_wa  <= m_wa;
        w_rw  <= m_rw;
    end

    // A PC-targeted write never forwards, so it is excluded once here for both operands.
    assign m_wr = m_valid & m_rw & (m_wa != PC_IDX);
    assign w_wr = w_valid & w_rw & (w_wa != PC_IDX);

    always_comb begin
        fwd_a = 3'b000;
        if (e_valid) begin
            if (e_ra1 == PC_IDX)
                fwd_a = 3'b011;
            else if (m_wr && m_wa == e_ra1)
                fwd_a = 3'b010;
            else if (w_wr && w_wa == e_ra1)
                fwd_a = 3'b001;
        end
    end

    always_comb begin
        fwd_b = 3'b000;
        if (e_valid) begin
            if (e_ra2 == PC_IDX)
                fwd_b = 3'b011;
            else if (m_wr && m_wa == e_ra2)
                fwd_b = 3'b010;
            else if (w_wr && w_wa == e_ra2)
                fwd_b = 3'b001;
        end
    end

    always_comb begin
        ldr_hz = e_valid & e_mr & e_rw & bus.valid_d & (e_wa != PC_IDX)
               & ((bus.ra1_d == e_wa) | (bus.ra2_d == e_wa));
        // A taken branch squashes the consumer anyway, so it overrides the stall.
        stall   = ldr_hz & ~bus.branch_taken_e;
        flush_e = ldr_hz | bus.branch_taken_e;
    end

    assign bus.fwd_a_e   = fwd_a;
    assign bus.fwd_b_e   = fwd_b;
    assign bus.stall_f   = stall;
    assign bus.stall_d   = stall;
    assign bus.flush_d   = bus.branch_taken_e;
    assign bus.flush_e   = flush_e;
    assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random instruction streams
// compared against an instruction-history reference model.
module tb_fwd_hazard_ctrl;
    localparam int unsigned RA_W   = 4;
    localparam int unsigned PC_REG = 15;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit          v;
        int unsigned ra1, ra2, wa;
        bit          rw, mr;
    } instr_t;

    logic clk;
    logic reset;

    fwd_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.RA_W(RA_W), .PC_REG(PC_REG), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: history of instructions that entered E; [0]=E, [1]=M, [2]=W.
    instr_t      hist[$];
    int unsigned m_cnt;
    instr_t      cur;
    bit          cur_br, cur_rst;
    int unsigned x_fa, x_fb;
    bit          x_stall, x_fd, x_fe;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit v, int unsigned ra1, int unsigned ra2, int unsigned wa,
                                  bit rw, bit mr);
        instr_t i;
        i.v = v; i.ra1 = ra1; i.ra2 = ra2; i.wa = wa; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic bit writes(instr_t i, int unsigned r);
        return i.v && i.rw && i.wa == r && r != PC_REG;
    endfunction

    // Nearest older producer wins: one instruction ahead is M (2), two ahead is W (1).
    function automatic int unsigned sel_for(int unsigned r);
        if (!hist[0].v) return 0;
        if (r == PC_REG) return 3;
        for (int d = 1; d <= 2; d++)
            if (writes(hist[d], r)) return 3 - d;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(mk(0, 0, 0, 0, 0, 0));
        m_cnt = 0;
    endtask

    task automatic apply(input bit r, input instr_t i, input bit b);
        bit ldr;
        cur = i; cur_br = b; cur_rst = r;
        reset              = r;
        bus.valid_d        = i.v;
        bus.ra1_d          = RA_W'(i.ra1);
        bus.ra2_d          = RA_W'(i.ra2);
        bus.wa_d           = RA_W'(i.wa);
        bus.regwrite_d     = i.rw;
        bus.memtoreg_d     = i.mr;
        bus.branch_taken_e = b;
        @(negedge clk);
        ldr = hist[0].v && hist[0].mr && hist[0].rw && i.v && hist[0].wa != PC_REG
              && (i.ra1 == hist[0].wa || i.ra2 == hist[0].wa);
        x_fa = sel_for(hist[0].ra1);
        x_fb = sel_for(hist[0].ra2);
        x_stall = ldr && !b;
        x_fd = b;
        x_fe = ldr || b;
        check("fwd_a_e",   bus.fwd_a_e,   x_fa);
        check("fwd_b_e",   bus.fwd_b_e,   x_fb);
        check("stall_f",   bus.stall_f,   x_stall);
        check("stall_d",   bus.stall_d,   x_stall);
        check("flush_d",   bus.flush_d,   x_fd);
        check("flush_e",   bus.flush_e,   x_fe);
        check("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    task automatic tick();
        instr_t n;
        @(posedge clk);
        if (cur_rst) begin
            model_reset();
        end else begin
            if (x_stall && m_cnt < CMAX) m_cnt++;
            n = cur;
            n.v = cur.v && !x_fe;
            hist.push_front(n);
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic step(input bit r, input instr_t i, input bit b);
        apply(r, i, b);
        tick();
    endtask

    function automatic int unsigned rreg();
        return ($urandom_range(0, 9) == 0) ? PC_REG : $urandom_range(0, 5);
    endfunction

    instr_t nop, ldr6, use6;

    initial begin
        nop  = mk(0, 0, 0, 0, 0, 0);
        ldr6 = mk(1, 8, 9, 6, 1, 1);
        use6 = mk(1, 6, 9, 10, 1, 0);

        reset = 1'b1;
        bus.valid_d = 1'b1; bus.ra1_d = '0; bus.ra2_d = '0; bus.wa_d = '0;
        bus.regwrite_d = 1'b1; bus.memtoreg_d = 1'b1; bus.branch_taken_e = 1'b0;
        @(posedge clk); #1;
        model_reset();
        cur_rst = 1'b0;

        // Reset state
        apply(0, mk(1, 3, 3, 3, 1, 1), 0);
        check("rst_fwd_a", bus.fwd_a_e, 0);
        check("rst_stall", bus.stall_d, 0);
        check("rst_cnt",   bus.stall_cnt, 0);
        tick();
        step(0, nop, 0); step(0, nop, 0); step(0, nop, 0);

        // Back-to-back: ADD r1 ; SUB r2,r1,r3
        step(0, mk(1, 2, 3, 1, 1, 0), 0);
        step(0, mk(1, 1, 3, 2, 1, 0), 0);
        apply(0, nop, 0);
        check("b2b_fwd_a", bus.fwd_a_e, 2);
        check("b2b_fwd_b", bus.fwd_b_e, 0);
        tick();

        // Distance 2 then distance 3 on operand B
        step(0, mk(1, 0, 0, 4, 1, 0), 0);
        step(0, mk(1, 8, 9, 7, 1, 0), 0);
        step(0, mk(1, 10, 4, 11, 1, 0), 0);
        apply(0, nop, 0);
        check("dist2_fwd_b", bus.fwd_b_e, 1);
        tick();
        step(0, mk(1, 0, 0, 4, 1, 0), 0);
        step(0, mk(1, 8, 9, 7, 1, 0), 0);
        step(0, mk(1, 8, 9, 12, 1, 0), 0);
        step(0, mk(1, 10, 4, 11, 1, 0), 0);
        apply(0, nop, 0);
        check("dist3_fwd_b", bus.fwd_b_e, 0);
        tick();

        // Double match: M priority
        step(0, mk(1, 0, 0, 5, 1, 0), 0);
        step(0, mk(1, 0, 0, 5, 1, 0), 0);
        step(0, mk(1, 5, 0, 13, 1, 0), 0);
        apply(0, nop, 0);
        check("dbl_fwd_a", bus.fwd_a_e, 2);
        tick();

        // Load-use: one stall, then forward from W
        step(0, ldr6, 0);
        apply(0, use6, 0);
        check("lu_stall_f", bus.stall_f, 1);
        check("lu_flush_e", bus.flush_e, 1);
        tick();
        apply(0, use6, 0);
        check("lu_release", bus.stall_d, 0);
        check("lu_cnt",     bus.stall_cnt, 1);
        tick();
        apply(0, nop, 0);
        check("lu_fwd_a", bus.fwd_a_e, 1);
        tick();

        // Branch beats load-use
        step(0, ldr6, 0);
        apply(0, use6, 1);
        check("br_stall_d", bus.stall_d, 0);
        check("br_flush_d", bus.flush_d, 1);
        check("br_flush_e", bus.flush_e, 1);
        tick();
        apply(0, nop, 0);
        check("br_cnt", bus.stall_cnt, 1);
        tick();

        // PC read wins over an M write to r15
        step(0, mk(1, 1, 2, 15, 1, 0), 0);
        step(0, mk(1, 15, 15, 3, 1, 0), 0);
        apply(0, nop, 0);
        check("pc_fwd_a", bus.fwd_a_e, 3);
        tick();

        // Random streams; D holds its instruction while stalled
        for (int c = 0; c < 600; c++) begin
            instr_t i;
            bit b, r;
            if (x_stall) i = cur;
            else i = mk($urandom_range(0, 4) != 0, rreg(), rreg(), rreg(),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(r, i, b);
        end

        // Saturation of the stall counter
        for (int k = 0; k < int'(CMAX) + 3; k++) begin
            step(0, ldr6, 0);
            step(0, use6, 0);
            step(0, use6, 0);
        end
        apply(0, nop, 0);
        check("sat_cnt", bus.stall_cnt, CMAX);
        tick();

        // Reset during an active stall
        step(0, ldr6, 0);
        apply(1, use6, 0);
        check("rst_mid_stall", bus.stall_d, 1);
        tick();
        apply(0, use6, 0);
        check("post_fwd_a",  bus.fwd_a_e, 0);
        check("post_fwd_b",  bus.fwd_b_e, 0);
        check("post_stall",  bus.stall_f, 0);
        check("post_stalld", bus.stall_d, 0);
        check("post_flushd", bus.flush_d, 0);
        check("post_flushe", bus.flush_e, 0);
        check("post_cnt",    bus.stall_cnt, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
